ucsbece154b_dmem_responder: RTL and testbench
=============================================

// Module: ucsbece154b_dmem_responder
// PURPOSE
//  Responder side of the pipelined core's M-stage data-memory port. It serves
//  word loads and stores to a local data RAM and to a small MMIO window.
//  The MMIO window holds a console TX FIFO, drained over a valid/ready byte
//  stream, plus optional performance counters. Sits beside the core in the
//  SoC top; the core's MemWriteM/ALUResultM/WriteDataM drive it and
//  ReadDataM_o feeds the core's ReadDataM.
// PARAMETERS
//  DMEM_BASE   32'h1000_0000  byte base address of data RAM
//  DMEM_WORDS  64             RAM depth in 32-bit words (power of 2, >=4)
//  MMIO_BASE   32'hFFFF_0000  byte base of 16-byte MMIO window
//  FIFO_DEPTH  8              console FIFO entries (power of 2, 2..128)
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  reset          in   1   asynchronous, active-low reset
//  MemWriteM_i    in   1   store strobe from M stage
//  ALUResultM_i   in   32  byte address
//  WriteDataM_i   in   32  store data
//  ReadDataM_o    out  32  load data, combinational from ALUResultM_i
//  tx_valid_o     out  1   console byte available
//  tx_data_o      out  8   head-of-FIFO byte
//  tx_ready_i     in   1   sink accepts byte when tx_valid_o&&tx_ready_i
//  err_o          out  1   sticky: bad store seen
// BEHAVIOUR
//  Reset (reset==0, async): FIFO empty, tx_valid_o=0, tx_data_o=0, overflow=0,
//   err_o=0, counters=0. RAM contents are not reset.
//  Decode: RAM hit = addr in [DMEM_BASE, DMEM_BASE+4*DMEM_WORDS); MMIO hit =
//   addr in [MMIO_BASE, MMIO_BASE+16). Index = addr[..:2]; addr[1:0] ignored on reads.
//  Reads: purely combinational, zero latency; unmapped -> 32'h0. No read strobe
//   exists, so reads never have side effects and never set err_o.
//  Stores: take effect at posedge when MemWriteM_i=1. Store with addr[1:0]!=0
//   or unmapped -> discarded, err_o<=1 (held until reset).
//  MMIO map (offset):
//   0x0 CONSOLE_DATA  W: push WriteDataM_i[7:0]; R: 0
//   0x4 CONSOLE_STAT  R: {16'b0, count[7:0], 5'b0, ovf, full, empty};
//                     W: bit2=1 clears ovf
//   0x8 CYCLE         R: cycle counter; W: counter<=0 (any data)
//   0xC STORES        R: count of accepted RAM stores; W: counter<=0
//  FIFO: push accepted iff !full || pop in same cycle; rejected push sets ovf.
//   pop = tx_valid_o && tx_ready_i. tx_valid_o = !empty (registered state, no
//   push-to-pop bypass: byte pushed in cycle N is visible in cycle N+1).
//   tx_data_o = head entry; holds stable while tx_valid_o && !tx_ready_i.
//   Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
//  Counters: 32-bit, wrap 2^32-1 -> 0. CYCLE += 1 every cycle unless written.
//   STORES += 1 per accepted RAM store. Write-clear wins over increment;
//   the value read the cycle after a clear is 0.
//  Reset mid-operation: FIFO contents dropped, valid deasserts immediately.
// CONFIGURATION
//  UCSBECE154B_PERF_CNT_EN defined: CYCLE/STORES registers implemented.
//  Undefined: no counter flops; offsets 0x8/0xC read 0; stores there are
//   silently ignored (not an error, err_o unaffected).
// TESTING
//  1 store 0xDEADBEEF @0x1000_0008, then read @0x1000_0008 -> 0xDEADBEEF,
//    @0x1000_000A read -> 0xDEADBEEF, err_o=0.
//  2 store @0x1000_0002 and @0x2000_0000 -> RAM unchanged, err_o=1 after first.
//  3 tx_ready_i=0; push 'A'..'H' (8) then 'I' -> STAT=0x0000_0806 (count 8,
//    ovf, full); raise ready -> bytes 'A'..'H' in order, then tx_valid_o=0.
//  4 FIFO full, push and pop same cycle -> push accepted, count stays 8, ovf=0.
//  5 PERF_CNT_EN: 3 RAM stores -> STORES=3; write CYCLE; next cycle CYCLE=0,
//    following cycle 1. Without macro -> both read 0.
//  6 assert reset low mid-drain with 5 queued -> tx_valid_o=0 asynchronously,
//    STAT=0x0000_0001 after release.

Source files
------------

// File: rtl/ucsbece154b_dmem_responder.sv
// ---------------------------------------------------------------------------
// ucsbece154b_dmem_responder
//
// Purpose:
//   Responder for the pipelined core's M-stage data-memory port. Serves
//   aligned word loads and stores to a local data RAM and to a 16-byte MMIO
//   window. The MMIO window holds a console TX FIFO, which is drained over a
//   valid/ready byte stream, plus optional performance counters.
//
// Optional feature macro:
//   UCSBECE154B_PERF_CNT_EN - when defined, the CYCLE and STORES counters are
//   implemented. When undefined, no counter flops exist, offsets 0x8/0xC read
//   as zero, and stores to them are silently dropped without raising err_o.
//
// Ports:
//   clk           in   1   clock; all state updates on posedge
//   reset         in   1   asynchronous, active-low reset
//   MemWriteM_i   in   1   store strobe from M stage
//   ALUResultM_i  in  32   byte address
//   WriteDataM_i  in  32   store data
//   ReadDataM_o   out 32   load data, combinational from ALUResultM_i
//   tx_valid_o    out  1   console byte available
//   tx_data_o     out  8   head-of-FIFO byte
//   tx_ready_i    in   1   sink accepts a byte when tx_valid_o && tx_ready_i
//   err_o         out  1   sticky: misaligned or unmapped store seen
//
// MMIO map (offset from MMIO_BASE):
//   0x0 CONSOLE_DATA  W: push WriteDataM_i[7:0]; R: 0
//   0x4 CONSOLE_STAT  R: {16'b0, count[7:0], 5'b0, ovf, full, empty}
//                     W: bit2 = 1 clears ovf
//   0x8 CYCLE         R: cycle counter;           W: clear
//   0xC STORES        R: accepted RAM store count; W: clear
// ---------------------------------------------------------------------------
module ucsbece154b_dmem_responder #(
  parameter logic [31:0] DMEM_BASE  = 32'h1000_0000,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM_i,
  input  logic [31:0] ALUResultM_i,
  input  logic [31:0] WriteDataM_i,
  output logic [31:0] ReadDataM_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        err_o
);

  localparam int          RAM_AW     = $clog2(DMEM_WORDS);
  localparam int          PTR_W      = $clog2(FIFO_DEPTH);
  localparam int          CNT_W      = PTR_W + 1;
  localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);
  localparam logic [31:0] MMIO_BYTES = 32'd16;

  localparam logic [1:0] REG_CONSOLE_DATA = 2'd0;
  localparam logic [1:0] REG_CONSOLE_STAT = 2'd1;
  localparam logic [1:0] REG_CYCLE        = 2'd2;
  localparam logic [1:0] REG_STORES       = 2'd3;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  // Subtract-then-compare gives a single unsigned range check per region and
  // the region-relative offset used for indexing.
  logic [31:0]       dmem_off;
  logic [31:0]       mmio_off;
  logic              ram_hit;
  logic              mmio_hit;
  logic              aligned;
  logic [RAM_AW-1:0] ram_idx;
  logic [1:0]        mmio_reg;

  assign dmem_off = ALUResultM_i - DMEM_BASE;
  assign mmio_off = ALUResultM_i - MMIO_BASE;
  assign ram_hit  = (dmem_off < DMEM_BYTES);
  assign mmio_hit = !ram_hit && (mmio_off < MMIO_BYTES);
  assign aligned  = (ALUResultM_i[1:0] == 2'b00);
  assign ram_idx  = dmem_off[RAM_AW+1:2];
  assign mmio_reg = mmio_off[3:2];

  // -------------------------------------------------------------------------
  // Store decode
  // -------------------------------------------------------------------------
  logic st_ok;
  logic bad_st;
  logic ram_we;
  logic push;
  logic stat_wr;

  assign st_ok   = MemWriteM_i && aligned && (ram_hit || mmio_hit);
  assign bad_st  = MemWriteM_i && !(aligned && (ram_hit || mmio_hit));
  assign ram_we  = st_ok && ram_hit;
  assign push    = st_ok && mmio_hit && (mmio_reg == REG_CONSOLE_DATA);
  assign stat_wr = st_ok && mmio_hit && (mmio_reg == REG_CONSOLE_STAT);

  // -------------------------------------------------------------------------
  // Data RAM (contents are not reset)
  // -------------------------------------------------------------------------
  logic [31:0] ram_mem [DMEM_WORDS];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_idx] <= WriteDataM_i;
    end
  end

  // -------------------------------------------------------------------------
  // Console TX FIFO
  // -------------------------------------------------------------------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push_ok;
  logic             push_rej;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && tx_ready_i;
  // A full FIFO can still take a byte when the head leaves in the same cycle;
  // the write then lands in the slot being vacated.
  assign push_ok    = push && (!fifo_full || pop);
  assign push_rej   = push && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= WriteDataM_i[7:0];
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    err_d    = err_q | bad_st;

    // Pointers are exactly PTR_W bits wide, so the increment wraps modulo
    // FIFO_DEPTH for free.
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (push_rej) begin
      ovf_d = 1'b1;
    end else if (stat_wr && WriteDataM_i[2]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage is not reset, so the head byte is gated to zero while empty;
  // this also forces tx_data_o low as soon as reset empties the FIFO.
  assign tx_valid_o = !fifo_empty;
  assign tx_data_o  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
  assign err_o      = err_q;

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
  logic [31:0] cycle_rd;
  logic [31:0] stores_rd;

`ifdef UCSBECE154B_PERF_CNT_EN
  logic        cyc_wr;
  logic        str_wr;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] stores_q, stores_d;

  assign cyc_wr = st_ok && mmio_hit && (mmio_reg == REG_CYCLE);
  assign str_wr = st_ok && mmio_hit && (mmio_reg == REG_STORES);

  // A clear has priority over the increment, so the first read after a
  // clear returns zero.
  always_comb begin
    cycle_d  = cyc_wr ? 32'd0 : cycle_q + 32'd1;
    stores_d = stores_q;
    if (str_wr) begin
      stores_d = 32'd0;
    end else if (ram_we) begin
      stores_d = stores_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q  <= 32'd0;
      stores_q <= 32'd0;
    end else begin
      cycle_q  <= cycle_d;
      stores_q <= stores_d;
    end
  end

  assign cycle_rd  = cycle_q;
  assign stores_rd = stores_q;
`else
  assign cycle_rd  = 32'd0;
  assign stores_rd = 32'd0;
`endif

  // -------------------------------------------------------------------------
  // Load path: combinational, no side effects
  // -------------------------------------------------------------------------
  logic [31:0] stat_word;

  assign stat_word = {16'b0, 8'(count_q), 5'b0, ovf_q, fifo_full, fifo_empty};

  always_comb begin
    ReadDataM_o = 32'd0;
    if (ram_hit) begin
      ReadDataM_o = ram_mem[ram_idx];
    end else if (mmio_hit) begin
      case (mmio_reg)
        REG_CONSOLE_STAT: ReadDataM_o = stat_word;
        REG_CYCLE:        ReadDataM_o = cycle_rd;
        REG_STORES:       ReadDataM_o = stores_rd;
        default:          ReadDataM_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ucsbece154b_dmem_responder.sv
module tb_ucsbece154b_dmem_responder;

  localparam logic [31:0] MMIO = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic        MemWriteM_i;
  logic [31:0] ALUResultM_i;
  logic [31:0] WriteDataM_i;
  logic [31:0] ReadDataM_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic        err_o;

  int n_cmp;
  int n_bad;

  ucsbece154b_dmem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .MemWriteM_i  (MemWriteM_i),
    .ALUResultM_i (ALUResultM_i),
    .WriteDataM_i (WriteDataM_i),
    .ReadDataM_o  (ReadDataM_o),
    .tx_valid_o   (tx_valid_o),
    .tx_data_o    (tx_data_o),
    .tx_ready_i   (tx_ready_i),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Store issued in the low phase, committed at the following posedge;
  // returns 1 time unit after that edge with the strobe dropped.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWriteM_i  = 1'b1;
    ALUResultM_i = a;
    WriteDataM_i = d;
    @(posedge clk);
    #1;
    MemWriteM_i  = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    MemWriteM_i  = 1'b0;
    ALUResultM_i = a;
    #1;
    d = ReadDataM_o;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    n_cmp++; if (tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", tx_valid_o); end
    n_cmp++; if (tx_data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", tx_data_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0b want 0", err_o); end
    do_read(MMIO + 32'h4, r);
    n_cmp++; if (r !== 32'h0000_0001) begin n_bad++; $display("FAIL reset_stat got %h want 00000001", r); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_ram;
    logic [31:0] r;
    do_store(32'h1000_0008, 32'hDEAD_BEEF);
    do_read(32'h1000_0008, r);
    n_cmp++; if (r !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_rd08 got %h want deadbeef", r); end
    do_read(32'h1000_000A, r);
    n_cmp++; if (r !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_rd0a got %h want deadbeef", r); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL ram_err got %0b want 0", err_o); end
    do_store(32'h1000_00FC, 32'h1234_5678);
    do_store(32'h1000_0000, 32'hCAFE_F00D);
    do_read(32'h1000_00FC, r);
    n_cmp++; if (r !== 32'h1234_5678) begin n_bad++; $display("FAIL ram_last got %h want 12345678", r); end
    do_read(32'h1000_0100, r);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL ram_past_end got %h want 0", r); end
    do_read(32'h1000_0000, r);
    n_cmp++; if (r !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL ram_first got %h want cafef00d", r); end
  endtask

  task automatic test_counters;
    logic [31:0] r;
`ifdef UCSBECE154B_PERF_CNT_EN
    do_store(MMIO + 32'hC, 32'h5555_5555);
    do_store(32'h1000_0010, 32'h1);
    do_store(32'h1000_0014, 32'h2);
    do_store(32'h1000_0018, 32'h3);
    do_read(MMIO + 32'hC, r);
    n_cmp++; if (r !== 32'd3) begin n_bad++; $display("FAIL stores_cnt got %0d want 3", r); end
    do_store(MMIO + 32'h8, 32'hFFFF_FFFF);
    do_read(MMIO + 32'h8, r);
    n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL cycle_clr got %0d want 0", r); end
    @(posedge clk);
    do_read(MMIO + 32'h8, r);
    n_cmp++; if (r !== 32'd1) begin n_bad++; $display("FAIL cycle_inc got %0d want 1", r); end
`else
    do_store(32'h1000_0010, 32'h1);
    do_read(MMIO + 32'h8, r);
    n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL cycle_off got %h want 0", r); end
    do_read(MMIO + 32'hC, r);
    n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL stores_off got %h want 0", r); end
    do_store(MMIO + 32'h8, 32'h7);
    do_store(MMIO + 32'hC, 32'h7);
    do_read(MMIO + 32'h8, r);
    n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL cycle_off_wr got %h want 0", r); end
`endif
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL cnt_err got %0b want 0", err_o); end
  endtask

  task automatic test_bad_store;
    logic [31:0] r;
    do_store(32'h1000_0002, 32'h1111_1111);
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL bad_misalign_err got %0b want 1", err_o); end
    do_read(32'h1000_0000, r);
    n_cmp++; if (r !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL bad_misalign_ram got %h want cafef00d", r); end
    do_store(32'h2000_0000, 32'h2222_2222);
    do_read(32'h2000_0000, r);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL unmapped_rd got %h want 0", r); end
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL bad_sticky got %0b want 1", err_o); end
  endtask

  task automatic test_fifo;
    logic [31:0] r;
    logic [7:0]  exp_q [8];
    tx_ready_i = 1'b0;
    // First push: not visible until the cycle after it is written.
    @(negedge clk);
    MemWriteM_i  = 1'b1;
    ALUResultM_i = MMIO;
    WriteDataM_i = 32'h41;
    #1;
    n_cmp++; if (tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL no_bypass got %0b want 0", tx_valid_o); end
    @(posedge clk);
    #1;
    MemWriteM_i = 1'b0;
    n_cmp++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h41) begin
      n_bad++; $display("FAIL first_push got v=%0b d=%h want v=1 d=41", tx_valid_o, tx_data_o);
    end
    for (int i = 1; i < 8; i++) do_store(MMIO, 32'(8'h41 + i));
    do_read(MMIO + 32'h4, r);
    n_cmp++; if (r !== 32'h0000_0802) begin n_bad++; $display("FAIL stat_full got %h want 00000802", r); end
    do_store(MMIO, 32'h49);
    do_read(MMIO + 32'h4, r);
    n_cmp++; if (r !== 32'h0000_0806) begin n_bad++; $display("FAIL stat_ovf got %h want 00000806", r); end
    do_read(MMIO, r);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL data_rd got %h want 0", r); end
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++; if (tx_data_o !== 8'h41) begin n_bad++; $display("FAIL head_hold got %h want 41", tx_data_o); end
    do_store(MMIO + 32'h4, 32'h4);
    do_read(MMIO + 32'h4, r);
    n_cmp++; if (r !== 32'h0000_0802) begin n_bad++; $display("FAIL ovf_clr got %h want 00000802", r); end
    // Full FIFO: push and pop in the same cycle.
    @(negedge clk);
    MemWriteM_i  = 1'b1;
    ALUResultM_i = MMIO;
    WriteDataM_i = 32'h4A;
    tx_ready_i   = 1'b1;
    #1;
    n_cmp++; if (tx_data_o !== 8'h41) begin n_bad++; $display("FAIL pp_head got %h want 41", tx_data_o); end
    @(posedge clk);
    #1;
    MemWriteM_i = 1'b0;
    tx_ready_i  = 1'b0;
    do_read(MMIO + 32'h4, r);
    n_cmp++; if (r !== 32'h0000_0802) begin n_bad++; $display("FAIL pp_stat got %h want 00000802", r); end
    exp_q = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h4A};
    tx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (tx_valid_o !== 1'b1 || tx_data_o !== exp_q[i]) begin
        n_bad++; $display("FAIL drain_%0d got v=%0b d=%h want v=1 d=%h", i, tx_valid_o, tx_data_o, exp_q[i]);
      end
    end
    @(posedge clk);
    #1;
    tx_ready_i = 1'b0;
    n_cmp++; if (tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL drain_done got %0b want 0", tx_valid_o); end
    do_read(MMIO + 32'h4, r);
    n_cmp++; if (r !== 32'h0000_0001) begin n_bad++; $display("FAIL drain_stat got %h want 00000001", r); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    tx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) do_store(MMIO, 32'(8'h4B + i));
    do_read(MMIO + 32'h4, r);
    n_cmp++; if (r !== 32'h0000_0500) begin n_bad++; $display("FAIL five_stat got %h want 00000500", r); end
    tx_ready_i = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h4C) begin
      n_bad++; $display("FAIL mid_head got v=%0b d=%h want v=1 d=4c", tx_valid_o, tx_data_o);
    end
    reset = 1'b0;
    #1;
    n_cmp++; if (tx_valid_o !== 1'b0 || tx_data_o !== 8'h00) begin
      n_bad++; $display("FAIL async_rst got v=%0b d=%h want v=0 d=00", tx_valid_o, tx_data_o);
    end
    @(negedge clk);
    @(negedge clk);
    reset      = 1'b1;
    tx_ready_i = 1'b0;
    @(posedge clk);
    #1;
    do_read(MMIO + 32'h4, r);
    n_cmp++; if (r !== 32'h0000_0001) begin n_bad++; $display("FAIL rst_stat got %h want 00000001", r); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got %0b want 0", err_o); end
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    reset        = 1'b1;
    MemWriteM_i  = 1'b0;
    ALUResultM_i = 32'h0;
    WriteDataM_i = 32'h0;
    tx_ready_i   = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    test_reset();
    test_ram();
    test_counters();
    test_bad_store();
    test_fifo();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
